// File: rtl/step_judge.sv
// Judge stage for the rhythm game: synchronizes arrow buttons, edge-detects presses and
// scores each arrow at the target line as a one-cycle hit (up) or miss (down) pulse.
module step_judge #(
  parameter int unsigned LANE_W = 2,
  parameter int unsigned WINDOW = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [(2**LANE_W)-1:0]   keys,
  input  logic                     arrow_valid,
  input  logic [LANE_W-1:0]        arrow_lane,
  output logic                     up,
  output logic                     down,
  output logic                     busy,
  output logic [3:0]               combo
);

  localparam int unsigned LANES = 2 ** LANE_W;
  localparam logic [7:0] Reload = 8'(WINDOW - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e             state_q;
  logic [LANES-1:0]   sync1_q, sync2_q, prev_q;
  logic [LANES-1:0]   press, lane_mask;
  logic [LANE_W-1:0]  lane_q;
  logic [7:0]         timer_q;
  logic               up_q, down_q;
  logic [3:0]         combo_q;
  logic               hit, any_press, resolved;

  assign press     = sync2_q & ~prev_q;
  assign lane_mask = LANES'(1) << lane_q;
  // A hit needs the latched lane alone; any extra lane in the same cycle is a mash.
  assign hit       = (press == lane_mask);
  assign any_press = |press;
  assign resolved  = any_press || (timer_q == 8'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      lane_q  <= '0;
      timer_q <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      combo_q <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (arrow_valid) begin
            lane_q  <= arrow_lane;
            timer_q <= Reload;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (hit) begin
            up_q <= 1'b1;
            if (combo_q != 4'd15) combo_q <= combo_q + 4'd1;
          end else if (resolved || arrow_valid) begin
            // Wrong lane, mash, timeout, or an overlapping arrow forcing resolution.
            down_q  <= 1'b1;
            combo_q <= '0;
          end
          if (resolved || arrow_valid) begin
            if (arrow_valid) begin
              lane_q  <= arrow_lane;
              timer_q <= Reload;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign up    = up_q;
  assign down  = down_q;
  assign busy  = (state_q == StWait);
  assign combo = combo_q;

endmodule

// File: tb/tb_step_judge.sv
// Bench for step_judge: constant vector table, hand sequences for combo/reset corners,
// and randomized traffic against an arrow-level reference model (WINDOW=8 and WINDOW=1).
module tb_step_judge;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keys = '0;
  logic       arrow_valid = 1'b0;
  logic [1:0] arrow_lane = '0;
  logic       up8, down8, busy8, up1, down1, busy1;
  logic [3:0] combo8, combo1;

  always #5 clock = ~clock;

  step_judge #(.LANE_W(2), .WINDOW(8)) dut (
    .clock(clock), .reset(reset), .keys(keys), .arrow_valid(arrow_valid),
    .arrow_lane(arrow_lane), .up(up8), .down(down8), .busy(busy8), .combo(combo8)
  );

  step_judge #(.LANE_W(2), .WINDOW(1)) dut_w1 (
    .clock(clock), .reset(reset), .keys(keys), .arrow_valid(arrow_valid),
    .arrow_lane(arrow_lane), .up(up1), .down(down1), .busy(busy1), .combo(combo1)
  );

  // Reference: one pending arrow with its lane and the number of window cycles used so far.
  typedef struct {
    bit pending;
    int lane;
    int age;
    int combo;
    bit up;
    bit down;
  } mstate_t;

  typedef struct {
    bit         v;
    int         lane;
    logic [3:0] k;
    bit         up;
    bit         dn;
    bit         busy;
    int         combo;
  } vec_t;

  int         total = 0;
  int         passed = 0;
  logic [3:0] km1 = '0, km2 = '0, km3 = '0;
  mstate_t    m8, m1;
  vec_t       tv[$];

  function automatic mstate_t mnext(mstate_t m, int window, bit valid, int lane,
                                    logic [3:0] press);
    mstate_t n;
    bit      res;
    n      = m;
    n.up   = 1'b0;
    n.down = 1'b0;
    res    = 1'b0;
    if (m.pending) begin
      if (press == 4'(1 << m.lane)) begin
        n.up    = 1'b1;
        n.combo = (m.combo < 15) ? m.combo + 1 : 15;
        res     = 1'b1;
      end else if (press != 0 || valid || m.age == window - 1) begin
        n.down  = 1'b1;
        n.combo = 0;
        res     = 1'b1;
      end else begin
        n.age = m.age + 1;
      end
    end
    if (!m.pending || res) begin
      n.pending = valid;
      n.lane    = lane;
      n.age     = 0;
    end
    return n;
  endfunction

  function automatic mstate_t mclear();
    mstate_t n;
    n = '{pending: 1'b0, lane: 0, age: 0, combo: 0, up: 1'b0, down: 1'b0};
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Drive one cycle's inputs, advance the models, then sample 1ns after the edge.
  task automatic step(input bit v, input int l, input logic [3:0] k);
    logic [3:0] pr;
    arrow_valid = v;
    arrow_lane  = 2'(l);
    keys        = k;
    pr  = km2 & ~km3;
    m8  = mnext(m8, 8, v, l, pr);
    m1  = mnext(m1, 1, v, l, pr);
    km3 = km2;
    km2 = km1;
    km1 = k;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_up", int'(up8), 0);
    check("rst_down", int'(down8), 0);
    check("rst_busy", int'(busy8), 0);
    check("rst_combo", int'(combo8), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    km1 = '0;
    km2 = '0;
    km3 = '0;
    m8  = mclear();
    m1  = mclear();
  endtask

  task automatic add(input int n, input bit v, input int l, input logic [3:0] k,
                     input bit u, input bit d, input bit b, input int c);
    for (int i = 0; i < n; i++) tv.push_back('{v, l, k, u, d, b, c});
  endtask

  initial begin
    logic [3:0] k;
    bit         v;
    int         l;
    m8 = mclear();
    m1 = mclear();

    // Hit on lane 2, key rises 3 cycles after the arrow.
    add(1, 1, 2, 4'b0000, 0, 0, 1, 0);
    add(2, 0, 0, 4'b0000, 0, 0, 1, 0);
    add(2, 0, 0, 4'b0100, 0, 0, 1, 0);
    add(1, 0, 0, 4'b0100, 1, 0, 0, 1);
    add(1, 0, 0, 4'b0100, 0, 0, 0, 1);
    add(2, 0, 0, 4'b0000, 0, 0, 0, 1);
    // Timeout on lane 1: busy for 8 cycles, then a miss.
    add(1, 1, 1, 4'b0000, 0, 0, 1, 1);
    add(7, 0, 0, 4'b0000, 0, 0, 1, 1);
    add(1, 0, 0, 4'b0000, 0, 1, 0, 0);
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0);
    // Wrong lane.
    add(1, 1, 0, 4'b0000, 0, 0, 1, 0);
    add(2, 0, 0, 4'b1000, 0, 0, 1, 0);
    add(1, 0, 0, 4'b1000, 0, 1, 0, 0);
    add(2, 0, 0, 4'b0000, 0, 0, 0, 0);
    // Mash: correct lane 0 plus lane 1 together.
    add(1, 1, 0, 4'b0000, 0, 0, 1, 0);
    add(2, 0, 0, 4'b0011, 0, 0, 1, 0);
    add(1, 0, 0, 4'b0011, 0, 1, 0, 0);
    add(2, 0, 0, 4'b0000, 0, 0, 0, 0);
    // Overlap: second arrow after 4 cycles resolves the first as a miss, then hit on lane 3.
    add(1, 1, 1, 4'b0000, 0, 0, 1, 0);
    add(3, 0, 0, 4'b0000, 0, 0, 1, 0);
    add(1, 1, 3, 4'b0000, 0, 1, 1, 0);
    add(2, 0, 0, 4'b1000, 0, 0, 1, 0);
    add(1, 0, 0, 4'b1000, 1, 0, 0, 1);
    add(2, 0, 0, 4'b0000, 0, 0, 0, 1);

    do_reset();
    foreach (tv[i]) begin
      step(tv[i].v, tv[i].lane, tv[i].k);
      check($sformatf("vec%0d_up", i), int'(up8), int'(tv[i].up));
      check($sformatf("vec%0d_down", i), int'(down8), int'(tv[i].dn));
      check($sformatf("vec%0d_busy", i), int'(busy8), int'(tv[i].busy));
      check($sformatf("vec%0d_combo", i), int'(combo8), tv[i].combo);
    end

    // Combo saturation over 17 hits, then one miss clears it.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      k = 4'(1 << (i % 4));
      step(1, i % 4, 4'b0000);
      step(0, 0, k);
      step(0, 0, k);
      step(0, 0, k);
      check($sformatf("sat%0d_up", i), int'(up8), 1);
      check($sformatf("sat%0d_combo", i), int'(combo8), (i < 15) ? i + 1 : 15);
      step(0, 0, 4'b0000);
    end
    step(1, 0, 4'b0000);
    step(0, 0, 4'b0010);
    step(0, 0, 4'b0010);
    step(0, 0, 4'b0010);
    check("sat_miss_down", int'(down8), 1);
    check("sat_miss_combo", int'(combo8), 0);
    step(0, 0, 4'b0000);

    // Mid-window asynchronous reset with lane-1 key held, after a hit set combo to 1.
    step(1, 1, 4'b0000);
    step(0, 0, 4'b0010);
    step(0, 0, 4'b0010);
    step(0, 0, 4'b0010);
    check("pre_rst_combo", int'(combo8), 1);
    step(0, 0, 4'b0000);
    step(1, 1, 4'b0010);
    step(0, 0, 4'b0010);
    check("pre_rst_busy", int'(busy8), 1);
    #2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'b0010);
      check($sformatf("held%0d_up", i), int'(up8), 0);
      check($sformatf("held%0d_down", i), int'(down8), 0);
      check($sformatf("held%0d_busy", i), int'(busy8), 0);
    end

    // WINDOW=1: a single evaluation cycle, then timeout.
    do_reset();
    step(1, 2, 4'b0000);
    check("w1_busy", int'(busy1), 1);
    step(0, 0, 4'b0000);
    check("w1_down", int'(down1), 1);
    check("w1_idle", int'(busy1), 0);

    // Random traffic against the reference model for both window sizes.
    do_reset();
    k = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0:       k = 4'b0000;
          3:       k = 4'($urandom);
          default: k = 4'(1 << $urandom_range(3));
        endcase
      end
      v = ($urandom_range(5) == 0);
      l = int'($urandom_range(3));
      step(v, l, k);
      check("rand_w8", int'({up8, down8, busy8, combo8}),
            int'({m8.up, m8.down, m8.pending, 4'(m8.combo)}));
      check("rand_w1", int'({up1, down1, busy1, combo1}),
            int'({m1.up, m1.down, m1.pending, 4'(m1.combo)}));
      check("rand_excl", int'(up8 & down8), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/step_judge.md
Name: step_judge

Overview:
Upstream judge stage for the per-digit score counters. It synchronizes the player's arrow buttons and detects their rising edges. It then judges each press against the arrow currently at the target line, within a fixed timing window. The result is a single-cycle UP pulse (hit) or DOWN pulse (miss), which drives the UP/DOWN inputs of the 0-9 saturating digit counter, plus a saturating combo count.

Parameters:
LANE_W, 2, lane index width; number of lanes LANES = 2**LANE_W (4 arrows)
WINDOW, 8, hit window length in clock cycles; legal range 1..255

Ports:
CLOCK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous, active-low reset; all state cleared while low
KEYS  input  LANES  raw asynchronous button levels, one bit per lane, 1 = pressed
ARROW_VALID  input  1  one-cycle pulse: a new arrow has reached the target line
ARROW_LANE  input  LANE_W  lane of that arrow, sampled only when ARROW_VALID=1
UP  output  1  one-cycle hit pulse to the score counter
DOWN  output  1  one-cycle miss pulse to the score counter
BUSY  output  1  high while a hit window is open
COMBO  output  4  consecutive hits, saturates at 15

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; UP=0, DOWN=0, BUSY=0, COMBO=0; timer=0; latched lane=0; both sync stages and the edge-detect history register = 0.
- Input conditioning:
  - 2-flop synchronizer per KEYS bit, then an edge detect: press[i] = sync2[i] & ~prev[i].
  - A key held through reset therefore yields one press 2 cycles after RESET rises. In IDLE that press is ignored.
- Latency: KEYS[i] rises and is stable before edge E0 -> press[i] high between E1 and E2 -> UP/DOWN registered at E2, high for exactly one cycle.
- UP and DOWN are registered outputs and are never high in the same cycle.
- FSM has 2 states, IDLE and WAIT. BUSY = (state == WAIT).
- IDLE:
  - ARROW_VALID=1: latch ARROW_LANE, timer <= WINDOW-1, go to WAIT.
  - Any press in IDLE: ignored, no pulse.
- WAIT, evaluated each cycle in this priority order:
  1. Press on the latched lane and no press on any other lane: UP=1 next cycle, COMBO += 1 (saturating at 15).
  2. Press on any other lane, including together with the correct lane (mash): DOWN=1, COMBO <= 0.
  3. No press and timer == 0: timeout, DOWN=1, COMBO <= 0.
  4. No press and timer != 0: timer -= 1, stay in WAIT, no pulse.
  - After a rule 1-3 resolution: if ARROW_VALID=1 in the same cycle, latch the new lane, reload the timer and stay in WAIT; otherwise go to IDLE.
  - ARROW_VALID=1 with no press and timer != 0: the old arrow is resolved as a miss (DOWN=1, COMBO <= 0), the new lane is latched, the timer is reloaded, and the FSM stays in WAIT.
- Window length: an arrow accepts presses during exactly WINDOW consecutive WAIT cycles. The first is the cycle after the ARROW_VALID edge. The timeout DOWN is registered at the edge ending the WINDOW-th cycle.
- WINDOW=1: a single evaluation cycle, then timeout.
- Only one arrow is judged at a time. An overlapping arrow always forces resolution of the previous one, so no arrow is silently dropped.
- A mid-operation reset abandons the open window with no pulse and clears COMBO.
- The timer is an 8-bit down-counter. Timer wrap is impossible because timeout is detected at 0.

Test Plan:
- Reset: RESET=0 asynchronously mid-window with KEYS=4'b0010 held -> UP=DOWN=BUSY=0, COMBO=0 immediately. After RESET rises, the held key's press in IDLE produces no pulse.
- Hit: ARROW_VALID with lane 2; KEYS[2] rises 3 cycles later -> UP high for exactly 1 cycle, 2 edges after the key is sampled; BUSY drops; COMBO=1; DOWN stays 0.
- Timeout: ARROW_VALID with lane 1, no keys -> BUSY high for 8 cycles, then DOWN high for 1 cycle, COMBO=0.
- Wrong lane and mash: arrow on lane 0, press KEYS[3] -> DOWN. Next arrow on lane 0 with KEYS[0] and KEYS[1] pressed in the same cycle -> DOWN, not UP.
- Overlap: arrow on lane 1, then a second ARROW_VALID on lane 3 after 4 cycles with no press -> DOWN for the first arrow, BUSY stays 1. Pressing KEYS[3] then gives UP.
- Combo saturation: 17 consecutive hits -> COMBO reads 15 after the 15th, 16th and 17th UP. One miss then -> COMBO=0.
